jk_excitation_driver: RTL and testbench

//  Inverse of a JK flip-flop bank: takes a target state word and drives J/K from the JK

---
 rtl/jk_excitation_driver_if.sv | 33 +++
 rtl/jk_excitation_driver.sv | 120 ++++++++++++
 tb/tb_jk_excitation_driver.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/jk_excitation_driver_if.sv
// jk_excitation_driver_if
//   Groups the signals between the stimulus source, the JK excitation driver
//   and the external JK flip-flop bank.
//   in_valid/in_target/in_ready : target-word handshake
//   Q                           : fed-back state of the JK bank
//   J/K                         : excitation inputs driven to the bank
//   done/match/err/err_cnt      : transaction status
//   slave  : the driver's view; master : the stimulus/bank side.
interface jk_excitation_driver_if #(
  parameter int unsigned N     = 4,
  parameter int unsigned CNT_W = 8
);
  logic             in_valid;
  logic [N-1:0]     in_target;
  logic             in_ready;
  logic [N-1:0]     Q;
  logic [N-1:0]     J;
  logic [N-1:0]     K;
  logic             done;
  logic             match;
  logic             err;
  logic [CNT_W-1:0] err_cnt;

  modport slave (
    input  in_valid, in_target, Q,
    output in_ready, J, K, done, match, err, err_cnt
  );

  modport master (
    output in_valid, in_target, Q,
    input  in_ready, J, K, done, match, err, err_cnt
  );
endinterface

// File: rtl/jk_excitation_driver.sv
// jk_excitation_driver
//   Drives J/K from the JK excitation table so that an external N-bit JK
//   bank reaches a requested target word on the next edge, then checks the
//   fed-back Q, re-drives on mismatch and reports done/match/err.
//   Clk   : clock, all state on posedge
//   Rst_n : asynchronous active-low reset
//   bus   : handshake, bank feedback/drive and status (see interface)
module jk_excitation_driver #(
  parameter int unsigned N         = 4,
  parameter bit          DC_MODE   = 1'b0,
  parameter int unsigned MAX_RETRY = 2,
  parameter int unsigned CNT_W     = 8
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  jk_excitation_driver_if.slave bus
);

  localparam int unsigned RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  typedef enum logic [1:0] {IDLE, DRIVE, CHECK} state_t;

  state_t           state_q, state_d;
  logic [N-1:0]     j_q, j_d, k_q, k_d;
  logic [N-1:0]     tgt_q, tgt_d;
  logic [RW-1:0]    retry_q, retry_d;
  logic             done_q, done_d, match_q, match_d, err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [N-1:0]     dc;
  logic [N-1:0]     exc_tgt, exc_j, exc_k;

  assign dc = DC_MODE ? '1 : '0;

  // Excitation table in vector form: a bit at 0 needs J=T (K don't-care),
  // a bit at 1 needs K=~T (J don't-care). The load target is the incoming
  // word on accept and the latched word on a retry reload.
  always_comb begin
    exc_tgt = (state_q == IDLE) ? bus.in_target : tgt_q;
    exc_j   = (~bus.Q & exc_tgt) | (bus.Q & dc);
    exc_k   = (bus.Q & ~exc_tgt) | (~bus.Q & dc);
  end

  always_comb begin
    state_d = state_q;
    j_d     = '0;
    k_d     = '0;
    tgt_d   = tgt_q;
    retry_d = retry_q;
    done_d  = 1'b0;
    match_d = 1'b0;
    err_d   = 1'b0;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          tgt_d   = bus.in_target;
          j_d     = exc_j;
          k_d     = exc_k;
          retry_d = '0;
          state_d = DRIVE;
        end
      end
      DRIVE: begin
        state_d = CHECK;
      end
      CHECK: begin
        if (bus.Q == tgt_q) begin
          done_d  = 1'b1;
          match_d = 1'b1;
          state_d = IDLE;
        end else if (32'(retry_q) < MAX_RETRY) begin
          retry_d = retry_q + 1'b1;
          j_d     = exc_j;
          k_d     = exc_k;
          state_d = DRIVE;
        end else begin
          done_d  = 1'b1;
          err_d   = 1'b1;
          if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= IDLE;
      j_q     <= '0;
      k_q     <= '0;
      tgt_q   <= '0;
      retry_q <= '0;
      done_q  <= 1'b0;
      match_q <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      j_q     <= j_d;
      k_q     <= k_d;
      tgt_q   <= tgt_d;
      retry_q <= retry_d;
      done_q  <= done_d;
      match_q <= match_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.in_ready = (state_q == IDLE);
  assign bus.J        = j_q;
  assign bus.K        = k_q;
  assign bus.done     = done_q;
  assign bus.match    = match_q;
  assign bus.err      = err_q;
  assign bus.err_cnt  = cnt_q;

endmodule

// File: tb/tb_jk_excitation_driver.sv
// tb_jk_excitation_driver
//   Two drivers (DC_MODE=0 with a 2-bit error counter, DC_MODE=1 with an
//   8-bit counter) share one stimulus stream; each feeds its own behavioural
//   JK bank with an optional stuck-at-0 mask.
module tb_jk_excitation_driver;

  logic Clk = 1'b0;
  logic Rst_n;
  always #5 Clk = ~Clk;

  jk_excitation_driver_if #(.N(4), .CNT_W(2)) aif ();
  jk_excitation_driver_if #(.N(4), .CNT_W(8)) bif ();

  jk_excitation_driver #(.N(4), .DC_MODE(1'b0), .MAX_RETRY(2), .CNT_W(2)) u_dut_a (
    .Clk(Clk), .Rst_n(Rst_n), .bus(aif.slave));
  jk_excitation_driver #(.N(4), .DC_MODE(1'b1), .MAX_RETRY(2), .CNT_W(8)) u_dut_b (
    .Clk(Clk), .Rst_n(Rst_n), .bus(bif.slave));

  assign bif.in_valid  = aif.in_valid;
  assign bif.in_target = aif.in_target;

  // Behavioural JK banks; stuck bits read 0 and are stored as 0.
  logic [3:0] stuck = '0;
  logic [3:0] qa_r = '0, qb_r = '0;

  function automatic logic [3:0] jk_next(input logic [3:0] q, j, k);
    logic [3:0] n;
    for (int i = 0; i < 4; i++)
      case ({j[i], k[i]})
        2'b00: n[i] = q[i];
        2'b01: n[i] = 1'b0;
        2'b10: n[i] = 1'b1;
        default: n[i] = ~q[i];
      endcase
    return n;
  endfunction

  always @(posedge Clk) begin
    qa_r <= jk_next(qa_r, aif.J, aif.K) & ~stuck;
    qb_r <= jk_next(qb_r, bif.J, bif.K) & ~stuck;
  end
  assign aif.Q = qa_r & ~stuck;
  assign bif.Q = qb_r & ~stuck;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model
  typedef struct {
    logic [3:0] j, k, jb, kb, q;
    logic       match, err;
    logic [1:0] cnt;
    logic [7:0] cntb;
    int         lat;
  } exp_t;
  exp_t sb[$];

  logic [3:0] qm = '0;
  int         cnt_a = 0, cnt_b = 0;

  function automatic void excite(input logic [3:0] q, t, input logic dc,
                                 output logic [3:0] j, k);
    for (int i = 0; i < 4; i++)
      case ({q[i], t[i]})
        2'b00: begin j[i] = 1'b0; k[i] = dc;   end
        2'b01: begin j[i] = 1'b1; k[i] = dc;   end
        2'b10: begin j[i] = dc;   k[i] = 1'b1; end
        default: begin j[i] = dc; k[i] = 1'b0; end
      endcase
  endfunction

  // Monitor
  int cyc = 0;
  int acc = -100;
  logic [3:0] cj, ck, cjb, ckb;
  always @(posedge Clk) cyc <= cyc + 1;

  always @(negedge Clk) begin
    if (Rst_n) begin
      if (cyc == acc + 1) begin
        cj = aif.J; ck = aif.K; cjb = bif.J; ckb = bif.K;
      end
      if (aif.done) begin
        chk("done_expected", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          exp_t e;
          e = sb.pop_front();
          chk("latency", cyc - acc, e.lat);
          chk("J_a", cj, e.j);
          chk("K_a", ck, e.k);
          chk("J_b", cjb, e.jb);
          chk("K_b", ckb, e.kb);
          chk("match_a", aif.match, e.match);
          chk("err_a", aif.err, e.err);
          chk("err_cnt_a", aif.err_cnt, e.cnt);
          chk("Q_a", aif.Q, e.q);
          chk("done_b", bif.done, 1);
          chk("match_b", bif.match, e.match);
          chk("err_cnt_b", bif.err_cnt, e.cntb);
          chk("Q_b", bif.Q, e.q);
        end
      end else begin
        chk("idle_flags", {aif.match, aif.err, bif.done}, 0);
      end
      if (aif.in_valid && aif.in_ready) acc = cyc;
    end
  end

  // Wait until the driver is idle again, pulsing in_valid while busy.
  task automatic wait_ready();
    int k = 0;
    do begin
      @(posedge Clk); #2;
      if (!aif.in_ready) begin
        aif.in_valid  = 1'($urandom_range(0, 1));
        aif.in_target = 4'($urandom);
      end
      k++;
    end while (!aif.in_ready && k < 20);
    chk("ready_timeout", aif.in_ready, 1);
    aif.in_valid = 1'b0;
  endtask

  // Called at posedge+2 of a cycle with in_ready=1.
  task automatic issue(input logic [3:0] t, input logic [3:0] s);
    exp_t e;
    if (s != stuck) begin
      aif.in_valid = 1'b0;
      @(negedge Clk); #1;
      stuck = s;
      @(posedge Clk); #2;
    end
    qm = qm & ~s;
    excite(qm, t, 1'b0, e.j, e.k);
    excite(qm, t, 1'b1, e.jb, e.kb);
    e.match = ((t & s) == 4'b0);
    e.err   = !e.match;
    e.lat   = e.match ? 3 : 7;
    if (!e.match) begin
      cnt_a = (cnt_a == 3) ? 3 : cnt_a + 1;
      cnt_b = cnt_b + 1;
    end
    e.cnt  = 2'(cnt_a);
    e.cntb = 8'(cnt_b);
    e.q    = t & ~s;
    qm     = e.q;
    sb.push_back(e);
    aif.in_valid  = 1'b1;
    aif.in_target = t;
    wait_ready();
  endtask

  initial begin
    Rst_n = 1'b0;
    aif.in_valid  = 1'b0;
    aif.in_target = '0;
    #3;
    chk("rst_J", aif.J, 0);
    chk("rst_K", aif.K, 0);
    chk("rst_flags", {aif.done, aif.match, aif.err}, 0);
    chk("rst_cnt", aif.err_cnt, 0);
    chk("rst_ready", aif.in_ready, 1);
    #14 Rst_n = 1'b1;
    @(posedge Clk); #2;

    issue(4'b1010, 4'b0000);
    issue(4'b0110, 4'b0000);
    issue(4'b1111, 4'b0000);
    issue(4'b1111, 4'b0000);
    for (int i = 0; i < 4; i++) issue(4'b0001, 4'b0001);
    issue(4'b0000, 4'b0000);
    issue(4'b0101, 4'b0000);

    // Asynchronous reset in the middle of DRIVE
    aif.in_valid  = 1'b1;
    aif.in_target = 4'b1010;
    @(posedge Clk); #2;
    aif.in_valid = 1'b0;
    #1 Rst_n = 1'b0;
    #1;
    chk("abort_J", aif.J, 0);
    chk("abort_K", aif.K, 0);
    chk("abort_ready", aif.in_ready, 1);
    chk("abort_done", aif.done, 0);
    chk("abort_cnt_a", aif.err_cnt, 0);
    chk("abort_cnt_b", bif.err_cnt, 0);
    cnt_a = 0;
    cnt_b = 0;
    #4 Rst_n = 1'b1;
    @(posedge Clk); #2;
    chk("post_abort_ready", aif.in_ready, 1);
    chk("post_abort_done", aif.done, 0);
    chk("post_abort_Q", aif.Q, qm);

    for (int i = 0; i < 60; i++) begin
      logic [3:0] s;
      s = ($urandom_range(0, 3) == 0) ? 4'(1 << $urandom_range(0, 3)) : 4'b0000;
      issue(4'($urandom), s);
      for (int g = $urandom_range(0, 2); g > 0; g--) begin
        @(posedge Clk); #2;
      end
    end

    repeat (3) @(posedge Clk);
    #2;
    chk("sb_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
